// File: rtl/plate_char_scan_scheduler_if.sv
// Bundle between the plate locator, the digit scanner and the scan scheduler.
// The scheduler takes the slave side; whoever supplies frames and plate boxes is the master.
interface plate_char_scan_scheduler_if #(
  parameter int N_CHAR = 7
);
  logic                  start;
  logic                  i_vs;
  logic                  plate_valid;
  logic [11:0]           plate_left;
  logic [11:0]           plate_up;
  logic [11:0]           plate_down;
  logic [3:0]            scan_digit;
  logic [11:0]           char_left;
  logic [11:0]           char_right;
  logic [11:0]           char_up;
  logic [11:0]           char_down;
  logic [2:0]            char_idx;
  logic                  busy;
  logic                  result_valid;
  logic [4*N_CHAR-1:0]   result_digits;
  logic                  abort;

  modport slave (
    input  start, i_vs, plate_valid, plate_left, plate_up, plate_down, scan_digit,
    output char_left, char_right, char_up, char_down, char_idx,
           busy, result_valid, result_digits, abort
  );

  modport master (
    output start, i_vs, plate_valid, plate_left, plate_up, plate_down, scan_digit,
    input  char_left, char_right, char_up, char_down, char_idx,
           busy, result_valid, result_digits, abort
  );
endinterface

// File: rtl/plate_char_scan_scheduler.sv
// Time-multiplexes one digit scanner over the character slots of a plate, DWELL_FRAMES
// frames per slot, and packs the captured digits into one result per pass.
//
// state | meaning
// IDLE  | waiting for start with a valid plate
// LOAD  | slot 0 box loaded, waiting for a frame end to align to a whole frame
// SCAN  | counting frame ends for the current slot, digit captured on the last one
// STEP  | advance to the next slot, or publish the result after the last slot
module plate_char_scan_scheduler #(
  parameter int N_CHAR       = 7,
  parameter int CHAR_PITCH   = 20,
  parameter int CHAR_W       = 45,
  parameter int DWELL_FRAMES = 2,
  parameter int CONTINUOUS   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  plate_char_scan_scheduler_if.slave  bus
);

  localparam logic [11:0] PITCH    = 12'(CHAR_PITCH);
  localparam logic [11:0] WIDTH    = 12'(CHAR_W);
  localparam logic [3:0]  DWELL    = 4'(DWELL_FRAMES);
  localparam logic [2:0]  LAST_IDX = 3'(N_CHAR - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, STEP} state_t;

  state_t              state;
  logic                vs_d;
  logic                vs_fall;
  logic [3:0]          frames_left;
  logic [4*N_CHAR-1:0] shadow;

  assign vs_fall = vs_d & ~bus.i_vs;

  // Right edge saturates at the last pixel column instead of wrapping.
  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      vs_d              <= 1'b0;
      frames_left       <= '0;
      shadow            <= '0;
      bus.char_left     <= '0;
      bus.char_right    <= '0;
      bus.char_up       <= '0;
      bus.char_down     <= '0;
      bus.char_idx      <= '0;
      bus.busy          <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.result_digits <= '0;
      bus.abort         <= 1'b0;
    end else begin
      vs_d             <= bus.i_vs;
      bus.result_valid <= 1'b0;
      bus.abort        <= 1'b0;
      // Losing the plate beats any frame end arriving in the same cycle.
      if (state != IDLE && !bus.plate_valid) begin
        bus.abort <= 1'b1;
        bus.busy  <= 1'b0;
        state     <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && bus.plate_valid) begin
              bus.char_left  <= bus.plate_left;
              bus.char_right <= sat_add(bus.plate_left, WIDTH);
              bus.char_up    <= bus.plate_up;
              bus.char_down  <= bus.plate_down;
              bus.char_idx   <= '0;
              frames_left    <= DWELL;
              bus.busy       <= 1'b1;
              state          <= LOAD;
            end
          end
          LOAD: begin
            if (vs_fall) state <= SCAN;
          end
          SCAN: begin
            if (vs_fall) begin
              if (frames_left == 4'd1) begin
                shadow[4*bus.char_idx +: 4] <= bus.scan_digit;
                state                       <= STEP;
              end else begin
                frames_left <= frames_left - 4'd1;
              end
            end
          end
          STEP: begin
            if (bus.char_idx == LAST_IDX) begin
              bus.result_digits <= shadow;
              bus.result_valid  <= 1'b1;
              if (CONTINUOUS != 0 && bus.plate_valid) begin
                bus.char_left  <= bus.plate_left;
                bus.char_right <= sat_add(bus.plate_left, WIDTH);
                bus.char_up    <= bus.plate_up;
                bus.char_down  <= bus.plate_down;
                bus.char_idx   <= '0;
                frames_left    <= DWELL;
                state          <= LOAD;
              end else begin
                bus.busy <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              bus.char_idx   <= bus.char_idx + 3'd1;
              bus.char_left  <= bus.char_left + PITCH;
              bus.char_right <= sat_add(bus.char_right, PITCH);
              frames_left    <= DWELL;
              state          <= SCAN;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plate_char_scan_scheduler.sv
// Directed bench for the plate character scan scheduler: one-shot and continuous instances
// share the clock, reset and frame/digit stimulus; start and plate box are per instance.
module tb_plate_char_scan_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  plate_char_scan_scheduler_if #(.N_CHAR(7)) m_if ();
  plate_char_scan_scheduler_if #(.N_CHAR(7)) c_if ();

  plate_char_scan_scheduler #(
    .N_CHAR(7), .CHAR_PITCH(20), .CHAR_W(45), .DWELL_FRAMES(2), .CONTINUOUS(0)
  ) dut_m (.clk(clk), .rst(rst), .bus(m_if.slave));

  plate_char_scan_scheduler #(
    .N_CHAR(7), .CHAR_PITCH(20), .CHAR_W(45), .DWELL_FRAMES(2), .CONTINUOUS(1)
  ) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  int checks = 0;
  int failures = 0;
  int falls = 0;
  int m_rv = 0, m_ab = 0, c_rv = 0, c_ab = 0;
  int m_rv_falls = 0;

  always @(negedge clk) begin
    if (m_if.result_valid === 1'b1) begin
      m_rv++;
      m_rv_falls = falls;
    end
    if (m_if.abort === 1'b1) m_ab++;
    if (c_if.result_valid === 1'b1) c_rv++;
    if (c_if.abort === 1'b1) c_ab++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One video frame: 8 active cycles, then a falling edge and 4 blanking cycles.
  task automatic frame(input logic [3:0] d, input bit pulse_start);
    m_if.scan_digit = d;
    c_if.scan_digit = d;
    m_if.i_vs = 1'b1;
    c_if.i_vs = 1'b1;
    step(3);
    if (pulse_start) m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    step(4);
    m_if.i_vs = 1'b0;
    c_if.i_vs = 1'b0;
    falls++;
    step(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {m_if.start, m_if.i_vs, m_if.plate_valid, c_if.start, c_if.i_vs, c_if.plate_valid} = '0;
    {m_if.plate_left, m_if.plate_up, m_if.plate_down, m_if.scan_digit} = '0;
    {c_if.plate_left, c_if.plate_up, c_if.plate_down, c_if.scan_digit} = '0;
    step(3);
    rst = 1'b0;
    step(1);
    checks++;
    if ({m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx,
         m_if.busy, m_if.result_valid, m_if.abort} !== 54'd0) begin
      failures++;
      $display("FAIL reset_outputs: got l=%0d r=%0d u=%0d d=%0d idx=%0d busy=%0b rv=%0b ab=%0b, expected all 0",
               m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx,
               m_if.busy, m_if.result_valid, m_if.abort);
    end
    checks++;
    if (m_if.result_digits !== 28'h0) begin
      failures++;
      $display("FAIL reset_digits: got %h expected 0000000", m_if.result_digits);
    end
  endtask

  task automatic test_scan_pass();
    int f0, rv0;
    m_if.plate_left = 12'd100; m_if.plate_up = 12'd200; m_if.plate_down = 12'd275;
    m_if.plate_valid = 1'b1;
    f0 = falls; rv0 = m_rv;
    m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    checks++;
    if ({m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx, m_if.busy}
        !== {12'd100, 12'd145, 12'd200, 12'd275, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL load_box: got l=%0d r=%0d u=%0d d=%0d idx=%0d busy=%0b expected 100 145 200 275 0 1",
               m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx, m_if.busy);
    end
    frame(4'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 2; j++) begin
        checks++;
        if ({m_if.char_left, m_if.char_right, m_if.char_idx, m_if.busy}
            !== {12'(100 + 20*k), 12'(145 + 20*k), 3'(k), 1'b1}) begin
          failures++;
          $display("FAIL slot_box k=%0d f=%0d: got l=%0d r=%0d idx=%0d busy=%0b expected %0d %0d %0d 1",
                   k, j, m_if.char_left, m_if.char_right, m_if.char_idx, m_if.busy,
                   100 + 20*k, 145 + 20*k, k);
        end
        frame(4'(k + 1), 1'b0);
      end
    end
    checks++;
    if (m_rv - rv0 !== 1) begin
      failures++;
      $display("FAIL result_pulse_width: got %0d high cycles expected 1", m_rv - rv0);
    end
    checks++;
    if (m_rv_falls - f0 !== 15) begin
      failures++;
      $display("FAIL result_latency: got %0d frame ends expected 15", m_rv_falls - f0);
    end
    checks++;
    if (m_if.result_digits !== 28'h7654321) begin
      failures++;
      $display("FAIL result_digits: got %h expected 7654321", m_if.result_digits);
    end
    checks++;
    if (m_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_pass: got %0b expected 0", m_if.busy);
    end
  endtask

  task automatic test_abort();
    int ab0, rv0;
    ab0 = m_ab; rv0 = m_rv;
    m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    frame(4'd0, 1'b0);
    for (int f = 0; f < 6; f++) frame(4'd5, 1'b0);
    m_if.i_vs = 1'b1; c_if.i_vs = 1'b1;
    step(3);
    checks++;
    if ({m_if.char_idx, m_if.busy} !== {3'd3, 1'b1}) begin
      failures++;
      $display("FAIL abort_pre_slot: got idx=%0d busy=%0b expected 3 1", m_if.char_idx, m_if.busy);
    end
    m_if.plate_valid = 1'b0;
    step(1);
    checks++;
    if ({m_if.abort, m_if.busy} !== 2'b10) begin
      failures++;
      $display("FAIL abort_pulse: got abort=%0b busy=%0b expected 1 0", m_if.abort, m_if.busy);
    end
    step(1);
    checks++;
    if (m_if.abort !== 1'b0) begin
      failures++;
      $display("FAIL abort_single: got abort=%0b expected 0", m_if.abort);
    end
    step(3);
    m_if.i_vs = 1'b0; c_if.i_vs = 1'b0;
    falls++;
    step(4);
    m_if.plate_valid = 1'b1;
    checks++;
    if (m_ab - ab0 !== 1) begin
      failures++;
      $display("FAIL abort_count: got %0d expected 1", m_ab - ab0);
    end
    checks++;
    if ({m_if.result_digits, 4'(m_rv - rv0)} !== {28'h7654321, 4'd0}) begin
      failures++;
      $display("FAIL abort_keeps_result: got digits=%h rv=%0d expected 7654321 0",
               m_if.result_digits, m_rv - rv0);
    end
  endtask

  task automatic test_start_ignored();
    int rv0;
    rv0 = m_rv;
    m_if.plate_valid = 1'b0;
    m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    step(1);
    checks++;
    if (m_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL start_without_plate: got busy=%0b expected 0", m_if.busy);
    end
    m_if.plate_valid = 1'b1;
    m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    frame(4'd0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 2; j++) begin
        checks++;
        if ({m_if.char_idx, m_if.char_left} !== {3'(k), 12'(100 + 20*k)}) begin
          failures++;
          $display("FAIL start_while_busy k=%0d f=%0d: got idx=%0d l=%0d expected %0d %0d",
                   k, j, m_if.char_idx, m_if.char_left, k, 100 + 20*k);
        end
        frame(4'(9 - k), 1'b1);
      end
    end
    checks++;
    if ({m_if.result_digits, 4'(m_rv - rv0)} !== {28'h3456789, 4'd1}) begin
      failures++;
      $display("FAIL restart_result: got digits=%h rv=%0d expected 3456789 1",
               m_if.result_digits, m_rv - rv0);
    end
  endtask

  task automatic test_back_to_back();
    int rv0, ab0;
    rv0 = c_rv; ab0 = c_ab;
    c_if.plate_left = 12'd100; c_if.plate_up = 12'd200; c_if.plate_down = 12'd275;
    c_if.plate_valid = 1'b1;
    c_if.start = 1'b1;
    step(1);
    c_if.start = 1'b0;
    frame(4'd0, 1'b0);
    for (int f = 0; f < 14; f++) frame(4'(f/2 + 1), 1'b0);
    checks++;
    if ({c_if.result_digits, 4'(c_rv - rv0)} !== {28'h7654321, 4'd1}) begin
      failures++;
      $display("FAIL cont_first: got digits=%h rv=%0d expected 7654321 1",
               c_if.result_digits, c_rv - rv0);
    end
    checks++;
    if ({c_if.busy, c_if.char_idx, c_if.char_left, c_if.char_right}
        !== {1'b1, 3'd0, 12'd100, 12'd145}) begin
      failures++;
      $display("FAIL cont_reload: got busy=%0b idx=%0d l=%0d r=%0d expected 1 0 100 145",
               c_if.busy, c_if.char_idx, c_if.char_left, c_if.char_right);
    end
    frame(4'd0, 1'b0);
    for (int f = 0; f < 14; f++) frame(4'(9 - f/2), 1'b0);
    checks++;
    if ({c_if.result_digits, 4'(c_rv - rv0)} !== {28'h3456789, 4'd2}) begin
      failures++;
      $display("FAIL cont_second: got digits=%h rv=%0d expected 3456789 2",
               c_if.result_digits, c_rv - rv0);
    end
    c_if.plate_valid = 1'b0;
    step(2);
    checks++;
    if ({c_if.busy, 4'(c_ab - ab0)} !== {1'b0, 4'd1}) begin
      failures++;
      $display("FAIL cont_stop: got busy=%0b aborts=%0d expected 0 1", c_if.busy, c_ab - ab0);
    end
  endtask

  task automatic test_clamp_and_reset();
    m_if.plate_left = 12'd4070; m_if.plate_up = 12'd10; m_if.plate_down = 12'd60;
    m_if.start = 1'b1;
    step(1);
    m_if.start = 1'b0;
    frame(4'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        checks++;
        if ({m_if.char_left, m_if.char_right} !== {12'(4070 + 20*k), 12'd4095}) begin
          failures++;
          $display("FAIL clamp k=%0d f=%0d: got l=%0d r=%0d expected %0d 4095",
                   k, j, m_if.char_left, m_if.char_right, 4070 + 20*k);
        end
        frame(4'd3, 1'b0);
      end
    end
    m_if.i_vs = 1'b1; c_if.i_vs = 1'b1;
    step(3);
    checks++;
    if ({m_if.char_right, m_if.char_idx, m_if.busy} !== {12'd4095, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL clamp_slot2: got r=%0d idx=%0d busy=%0b expected 4095 2 1",
               m_if.char_right, m_if.char_idx, m_if.busy);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if ({m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx,
         m_if.busy, m_if.result_valid, m_if.abort, m_if.result_digits} !== 82'd0) begin
      failures++;
      $display("FAIL reset_mid_scan: got l=%0d r=%0d u=%0d d=%0d idx=%0d busy=%0b rv=%0b ab=%0b digits=%h expected all 0",
               m_if.char_left, m_if.char_right, m_if.char_up, m_if.char_down, m_if.char_idx,
               m_if.busy, m_if.result_valid, m_if.abort, m_if.result_digits);
    end
    rst = 1'b0;
    m_if.i_vs = 1'b0; c_if.i_vs = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_scan_pass();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_clamp_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
